// File: rtl/sprite_mem_writer.sv
// Write-side controller for the sprite memory: takes a load command (element, base, count)
// and streams pixel words into the memory write port, optionally only during blanking.
module sprite_mem_writer #(
    parameter int ELEMENT_W  = 3,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 12,
    parameter int DEPTH      = 1024,
    parameter int BLANK_ONLY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ELEMENT_W-1:0] cmd_element,
    input  logic [ADDR_W-1:0]    cmd_base,
    input  logic [ADDR_W:0]      cmd_count,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic [DATA_W-1:0]    pix_data,
    input  logic                 abort,
    input  logic                 video_enable,
    output logic                 wr_enable,
    output logic [ELEMENT_W-1:0] wr_element,
    output logic [ADDR_W-1:0]    wr_address,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [ADDR_W+1:0] DEPTH_L = (ADDR_W + 2)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_L   = (ADDR_W + 1)'(1);

    logic [1:0]           state_reg;
    logic [1:0]           state_next;
    logic [ELEMENT_W-1:0] elem_reg;
    logic [ADDR_W-1:0]    base_reg;
    logic [ADDR_W:0]      count_reg;
    logic [ADDR_W:0]      index_reg;

    logic [ADDR_W+1:0]    cmd_end;
    logic                 cmd_bad;
    logic                 cmd_fire;
    logic                 pix_fire;
    logic                 last_word;

    // Extra headroom bits keep base+count exact so the range check cannot alias.
    assign cmd_end   = {2'b00, cmd_base} + {1'b0, cmd_count};
    assign cmd_bad   = (cmd_count == '0) || (cmd_end > DEPTH_L);

    // Holding cmd_ready low during reset keeps the loader from seeing a bogus accept.
    assign cmd_ready = (state_reg == IDLE) && reset;
    assign pix_ready = (state_reg == LOAD) && ((BLANK_ONLY == 0) || !video_enable);
    assign busy      = (state_reg != IDLE);

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign pix_fire  = pix_valid && pix_ready && !abort;
    assign last_word = (index_reg == (count_reg - ONE_L));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_fire && !cmd_bad) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (pix_fire && last_word) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= IDLE;
            elem_reg   <= '0;
            base_reg   <= '0;
            count_reg  <= '0;
            index_reg  <= '0;
            wr_enable  <= 1'b0;
            wr_element <= '0;
            wr_address <= '0;
            wr_data    <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state_reg <= state_next;
            wr_enable <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;

            if (cmd_fire) begin
                if (cmd_bad) begin
                    error <= 1'b1;
                end else begin
                    elem_reg  <= cmd_element;
                    base_reg  <= cmd_base;
                    count_reg <= cmd_count;
                    index_reg <= '0;
                end
            end

            // Range check at accept time guarantees base+index never wraps.
            if (pix_fire) begin
                wr_enable  <= 1'b1;
                wr_element <= elem_reg;
                wr_address <= base_reg + index_reg[ADDR_W-1:0];
                wr_data    <= pix_data;
                index_reg  <= index_reg + ONE_L;
                if (last_word) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_mem_writer.sv
// Directed bench for sprite_mem_writer: a transaction-level model predicts every output
// each cycle, and a write log is checked against hand-computed addresses and data.
module tb_sprite_mem_writer;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_element;
    logic [9:0]  cmd_base;
    logic [10:0] cmd_count;
    logic        pix_valid;
    logic        pix_ready;
    logic [11:0] pix_data;
    logic        abort;
    logic        video_enable;
    logic        wr_enable;
    logic [2:0]  wr_element;
    logic [9:0]  wr_address;
    logic [11:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;

    sprite_mem_writer #(
        .ELEMENT_W(3), .ADDR_W(10), .DATA_W(12), .DEPTH(1024), .BLANK_ONLY(1)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_element(cmd_element),
        .cmd_base(cmd_base), .cmd_count(cmd_count),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .abort(abort), .video_enable(video_enable),
        .wr_enable(wr_enable), .wr_element(wr_element), .wr_address(wr_address),
        .wr_data(wr_data), .busy(busy), .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cycle = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Transaction-level model: phase 0 idle, 1 loading, 2 completion cycle.
    bit          chk_en = 0;
    int          m_phase = 0;
    int          m_next, m_left;
    logic [2:0]  m_elem;
    bit          m_took = 0;
    bit          m_wr = 0, m_done = 0, m_err = 0;
    logic [2:0]  m_welem = '0;
    logic [9:0]  m_waddr = '0;
    logic [11:0] m_wdata = '0;

    always @(posedge clk) begin
        cycle++;
        m_took = 0;
        if (!reset) begin
            chk_en  = 1;
            m_phase = 0;
            m_wr = 0; m_done = 0; m_err = 0;
            m_welem = '0; m_waddr = '0; m_wdata = '0;
        end else begin
            m_wr = 0; m_done = 0; m_err = 0;
            case (m_phase)
                0: if (cmd_valid) begin
                    if (cmd_count == 0 || int'(cmd_base) + int'(cmd_count) > 1024) begin
                        m_err = 1;
                    end else begin
                        m_phase = 1;
                        m_elem  = cmd_element;
                        m_next  = int'(cmd_base);
                        m_left  = int'(cmd_count);
                    end
                end
                1: if (abort) begin
                    m_phase = 0;
                end else if (pix_valid && !video_enable) begin
                    m_took  = 1;
                    m_wr    = 1;
                    m_welem = m_elem;
                    m_waddr = 10'(m_next);
                    m_wdata = pix_data;
                    m_next++;
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 2;
                        m_done  = 1;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Write log of what the DUT actually emitted, for the literal checks.
    int          log_n = 0, done_n = 0, err_n = 0;
    logic [9:0]  log_addr [0:63];
    logic [11:0] log_data [0:63];
    logic [2:0]  log_elem [0:63];
    bit          log_done [0:63];
    int          log_cyc  [0:63];

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmd_ready", cmd_ready, (m_phase == 0 && reset) ? 1 : 0);
            check("pix_ready", pix_ready, (m_phase == 1 && !video_enable) ? 1 : 0);
            check("busy", busy, (m_phase != 0) ? 1 : 0);
            check("wr_enable", wr_enable, m_wr);
            check("wr_element", wr_element, m_welem);
            check("wr_address", wr_address, m_waddr);
            check("wr_data", wr_data, m_wdata);
            check("done", done, m_done);
            check("error", error, m_err);
            if (wr_enable === 1'b1 && log_n < 64) begin
                log_addr[log_n] = wr_address;
                log_data[log_n] = wr_data;
                log_elem[log_n] = wr_element;
                log_done[log_n] = (done === 1'b1);
                log_cyc[log_n]  = cycle;
                log_n++;
            end
            if (done === 1'b1) done_n++;
            if (error === 1'b1) err_n++;
        end
    end

    logic [11:0] words [0:7];
    int stall_k = -1;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic send_cmd(input logic [2:0] e, input logic [9:0] b, input logic [10:0] c);
        cmd_valid = 1; cmd_element = e; cmd_base = b; cmd_count = c;
        cyc();
        cmd_valid = 0;
        $display("[TB] cmd element=%0d base=%0d count=%0d", e, b, c);
    endtask

    task automatic feed(input int n);
        int t;
        for (int k = 0; k < n; k++) begin
            pix_valid = 1;
            pix_data  = words[k];
            if (k == stall_k) begin
                video_enable = 1;
                idle(2);
                video_enable = 0;
            end
            t = 0;
            do begin
                cyc();
                t++;
            end while (!m_took && t < 100);
            if (!m_took) begin
                fails++;
                tests++;
                $display("FAIL feed_timeout: word %0d not taken in 100 cycles", k);
            end
            $display("[TB] pixel %0d data=%03h", k, words[k]);
        end
        pix_valid = 0;
    endtask

    int n0, d0, e0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0; cmd_valid = 0; cmd_element = 0; cmd_base = 0; cmd_count = 0;
        pix_valid = 0; pix_data = 0; abort = 0; video_enable = 0;
        idle(3);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_wr_enable", wr_enable, 0);
        check("rst_wr_address", wr_address, 0);
        reset = 1;
        #1;
        check("rel_cmd_ready", cmd_ready, 1);
        check("rel_busy", busy, 0);
        check("rel_done", done, 0);
        check("rel_error", error, 0);
        idle(2);

        // Basic load of four pixels, back to back.
        words[0] = 12'hF00; words[1] = 12'h0F0; words[2] = 12'h00F; words[3] = 12'hFFF;
        n0 = log_n; d0 = done_n;
        send_cmd(3'd2, 10'd100, 11'd4);
        feed(4);
        idle(3);
        check("basic_count", log_n - n0, 4);
        check("basic_done_n", done_n - d0, 1);
        for (int k = 0; k < 4; k++) begin
            check("basic_addr", log_addr[n0 + k], 100 + k);
            check("basic_data", log_data[n0 + k], words[k]);
            check("basic_elem", log_elem[n0 + k], 2);
            check("basic_done_pos", log_done[n0 + k], (k == 3) ? 1 : 0);
        end
        check("basic_burst", log_cyc[n0 + 3] - log_cyc[n0], 3);

        // Range errors, then exact fit at the top of memory.
        n0 = log_n; e0 = err_n;
        send_cmd(3'd0, 10'd1020, 11'd5);
        idle(2);
        check("err_overrun", err_n - e0, 1);
        send_cmd(3'd0, 10'd1020, 11'd0);
        idle(2);
        check("err_zero", err_n - e0, 2);
        check("err_no_write", log_n - n0, 0);
        words[0] = 12'h123; words[1] = 12'h456; words[2] = 12'h789; words[3] = 12'hABC;
        send_cmd(3'd5, 10'd1020, 11'd4);
        feed(4);
        idle(3);
        check("top_count", log_n - n0, 4);
        check("top_first_addr", log_addr[n0], 1020);
        check("top_last_addr", log_addr[n0 + 3], 1023);
        check("top_last_data", log_data[n0 + 3], 12'hABC);
        check("top_elem", log_elem[n0 + 3], 5);

        // Stall while the display is active, before and mid-stream.
        words[0] = 12'h111; words[1] = 12'h222; words[2] = 12'h333;
        n0 = log_n;
        send_cmd(3'd1, 10'd200, 11'd3);
        video_enable = 1; pix_valid = 1; pix_data = words[0];
        idle(4);
        check("stall_no_write", log_n - n0, 0);
        video_enable = 0;
        stall_k = 2;
        feed(3);
        stall_k = -1;
        idle(3);
        check("stall_count", log_n - n0, 3);
        for (int k = 0; k < 3; k++) begin
            check("stall_addr", log_addr[n0 + k], 200 + k);
            check("stall_data", log_data[n0 + k], words[k]);
        end

        // Abort on the third word of eight.
        words[0] = 12'h0A1; words[1] = 12'h0A2; words[2] = 12'h0A3;
        n0 = log_n; d0 = done_n;
        send_cmd(3'd3, 10'd300, 11'd8);
        feed(2);
        pix_valid = 1; pix_data = words[2]; abort = 1;
        cyc();
        abort = 0; pix_valid = 0;
        check("abort_busy", busy, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        idle(2);
        check("abort_count", log_n - n0, 2);
        check("abort_no_done", done_n - d0, 0);
        words[0] = 12'hABC;
        send_cmd(3'd4, 10'd0, 11'd1);
        feed(1);
        idle(3);
        check("after_abort_addr", log_addr[log_n - 1], 0);
        check("after_abort_data", log_data[log_n - 1], 12'hABC);
        check("after_abort_elem", log_elem[log_n - 1], 4);

        // Reset in the middle of a load.
        words[0] = 12'h501; words[1] = 12'h502; words[2] = 12'h503; words[3] = 12'h504;
        n0 = log_n; d0 = done_n;
        send_cmd(3'd6, 10'd500, 11'd6);
        feed(3);
        reset = 0; pix_valid = 1; pix_data = words[3];
        idle(2);
        reset = 1; pix_valid = 0;
        #1;
        check("rst_mid_cmd_ready", cmd_ready, 1);
        idle(4);
        check("rst_mid_count", log_n - n0, 3);
        check("rst_mid_no_done", done_n - d0, 0);
        check("rst_mid_last_addr", log_addr[log_n - 1], 502);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sprite_mem_writer.md
# sprite_mem_writer

Write-side controller for the sprite memory: accepts a load command (element, base address, word count) and a stream of 12-bit RGB pixel words, and produces the write strobes, element select, address and data for the sprite memory's write port. It sits between the host/loader logic and the sprite memory, mirroring the read path that fetches pixels during scan-out. Optional blanking-only mode stalls writes while the display is in its active area.

## Interface
Parameters:
- ELEMENT_W, 3, width of sprite element index
- ADDR_W, 10, sprite word address width
- DATA_W, 12, pixel word width (4R,4G,4B)
- DEPTH, 1024, words per element; legal addresses 0..DEPTH-1
- BLANK_ONLY, 1, when 1 pixel writes are accepted only while video_enable=0

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-low reset
- cmd_valid  in  1  load command present
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- cmd_element  in  ELEMENT_W  target sprite element
- cmd_base  in  ADDR_W  first write address
- cmd_count  in  ADDR_W+1  number of words to write (1..DEPTH)
- pix_valid  in  1  pixel word present
- pix_ready  out  1  pixel accepted when pix_valid&pix_ready
- pix_data  in  DATA_W  pixel word
- abort  in  1  cancel current load
- video_enable  in  1  active display area flag from sync generator
- wr_enable  out  1  one-cycle write strobe to sprite memory
- wr_element  out  ELEMENT_W  element select for write
- wr_address  out  ADDR_W  write address
- wr_data  out  DATA_W  write data
- busy  out  1  load in progress
- done  out  1  one-cycle pulse, load completed
- error  out  1  one-cycle pulse, command rejected

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE: cmd_ready=1, pix_ready=0, busy=0. On cmd_valid: compute base+count in ADDR_W+2 bits. If count==0 or base+count>DEPTH → error pulse next cycle, command consumed, stay IDLE. Else latch element, base, count; index←0; go LOAD.
- LOAD: cmd_ready=0, busy=1. pix_ready = !BLANK_ONLY | !video_enable. On pixel handshake: register wr_enable=1, wr_address=base+index (ADDR_W, no wrap possible after range check), wr_element, wr_data=pix_data; index++. Handshake on word count-1 → DONE.
- abort in LOAD (priority over a same-cycle handshake: that word is not written) → IDLE next cycle; no done; words already written remain.
- DONE: busy=1, cmd_ready=0, pix_ready=0; exactly one cycle, then IDLE.
- abort in IDLE/DONE: ignored.
- wr_element/wr_address/wr_data hold last values when wr_enable=0.

## Timing
- Reset (reset=0 at clk edge): state IDLE, wr_enable=0, wr_element=0, wr_address=0, wr_data=0, done=0, error=0, index=0; busy=0, pix_ready=0; cmd_ready=0 while reset held, 1 first cycle after release.
- cmd_ready, pix_ready, busy: combinational from state (and video_enable). wr_*, done, error: registered.
- Write latency: handshake at edge N → wr_enable high for cycle N..N+1, one cycle.
- Last word handshake at edge N → last wr_enable and done both high in the following cycle; cmd_ready=1 one cycle later (command-to-command minimum gap 1 cycle after done).
- Throughput: one word per cycle when pix_valid held and not stalled.
- BLANK_ONLY=1: video_enable rising in LOAD drops pix_ready same cycle; no word lost; resumes when video_enable falls.
- Reset asserted mid-LOAD: FSM to IDLE on that edge, no further writes, no done.

## Test plan
- Reset release: all registered outputs 0, cmd_ready=1 next cycle, busy=0.
- Cmd element=2, base=100, count=4, pixels 0xF00,0x0F0,0x00F,0xFFF back-to-back, video_enable=0 → 4 consecutive wr_enable cycles at addresses 100..103 with those data, wr_element=2, done pulse with 4th write.
- Cmd base=1020, count=5 → error pulse 1 cycle, no wr_enable, cmd_ready stays 1; count=0 also → error; base=1020,count=4 → accepted, writes 1020..1023.
- BLANK_ONLY=1, video_enable=1 during LOAD with pix_valid=1 → pix_ready=0, no writes; drop video_enable → writes resume in order, none duplicated or dropped.
- abort asserted with handshake on 3rd of 8 words → only 2 writes, no done, IDLE next cycle, new cmd accepted.
- reset=0 mid-LOAD after 3 writes → no further wr_enable, done never pulses, cmd_ready=1 after release.
